// File: rtl/pick_sum_game.sv
// Pick-sum game controller: computer and human alternately claim numbers 1..NUM_MAX;
// the first to hold three numbers summing to TARGET wins.
module pick_sum_game #(
  parameter int NUM_MAX = 9,
  parameter int TARGET  = 15,
  parameter int PICKS   = 4,
  parameter int FIRST   = 5,
  localparam int W      = $clog2(NUM_MAX + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               newGame_L,
  input  logic               enter_L,
  input  logic [W-1:0]       hMove,
  output logic [W-1:0]       cMove,
  output logic [PICKS*W-1:0] hPicks,
  output logic [PICKS*W-1:0] cPicks,
  output logic               cWin,
  output logic               hWin,
  output logic               draw,
  output logic               illegal
);

  typedef logic [W-1:0]       num_t;
  typedef logic [W+1:0]       sum_t;
  typedef logic [NUM_MAX:1]   set_t;
  typedef enum logic [1:0] {COMP, WAIT_H, WAIT_REL, DONE} state_t;

  state_t state, state_nx;
  set_t   c_set, c_set_nx, h_set, h_set_nx;
  num_t   c_move, c_move_nx;
  logic   c_win, c_win_nx, h_win, h_win_nx, draw_r, draw_nx, illegal_r, illegal_nx;
  num_t   pick;
  set_t   c_after, h_hit;

  function automatic logic is_triple(input int a, input int b, input int c);
    sum_t s;
    s = sum_t'(a) + sum_t'(b) + sum_t'(c);
    return s == sum_t'(TARGET);
  endfunction

  function automatic logic has_win(input set_t s);
    logic r;
    r = 1'b0;
    for (int a = 1; a <= NUM_MAX; a++)
      for (int b = a + 1; b <= NUM_MAX; b++)
        for (int c = b + 1; c <= NUM_MAX; c++)
          if (s[a] && s[b] && s[c] && is_triple(a, b, c)) r = 1'b1;
    return r;
  endfunction

  // True when x plus two distinct members of s (neither equal to x) hits TARGET.
  function automatic logic completes(input set_t s, input int x);
    logic r;
    r = 1'b0;
    for (int a = 1; a <= NUM_MAX; a++)
      for (int b = a + 1; b <= NUM_MAX; b++)
        if (s[a] && s[b] && a != x && b != x && is_triple(a, b, x)) r = 1'b1;
    return r;
  endfunction

  // Descending scan so the last hit in each class is the smallest candidate.
  function automatic num_t choose(input set_t mine, input set_t theirs);
    num_t p_win, p_block, p_any;
    logic f_win, f_block;
    set_t used;
    used = mine | theirs;
    p_win = '0; p_block = '0; p_any = '0;
    f_win = 1'b0; f_block = 1'b0;
    for (int x = NUM_MAX; x >= 1; x--) begin
      if (!used[x]) begin
        p_any = num_t'(x);
        if (completes(mine, x))   begin p_win = num_t'(x);   f_win = 1'b1;   end
        if (completes(theirs, x)) begin p_block = num_t'(x); f_block = 1'b1; end
      end
    end
    return f_win ? p_win : (f_block ? p_block : p_any);
  endfunction

  function automatic int count(input set_t s);
    int n;
    n = 0;
    for (int i = 1; i <= NUM_MAX; i++) n += int'(s[i]);
    return n;
  endfunction

  function automatic set_t to_set(input num_t v);
    set_t r;
    r = '0;
    for (int i = 1; i <= NUM_MAX; i++) if (v == num_t'(i)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [PICKS*W-1:0] pack(input set_t s);
    logic [PICKS*W-1:0] r;
    int idx;
    r = '0;
    idx = 0;
    for (int x = 1; x <= NUM_MAX; x++) begin
      if (s[x] && idx < PICKS) begin
        r[idx*W +: W] = num_t'(x);
        idx++;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_nx   = state;
    c_set_nx   = c_set;
    h_set_nx   = h_set;
    c_move_nx  = c_move;
    c_win_nx   = c_win;
    h_win_nx   = h_win;
    draw_nx    = draw_r;
    illegal_nx = illegal_r;
    pick       = (c_set == '0) ? num_t'(FIRST) : choose(c_set, h_set);
    c_after    = c_set | to_set(pick);
    h_hit      = to_set(hMove);
    case (state)
      COMP: begin
        c_set_nx  = c_after;
        c_move_nx = pick;
        if (has_win(c_after)) begin
          c_win_nx = 1'b1;
          state_nx = DONE;
        end else if (&(c_after | h_set) || count(h_set) >= PICKS) begin
          draw_nx  = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = WAIT_H;
        end
      end
      WAIT_H: begin
        if (!enter_L) begin
          // An out-of-range hMove maps to an empty set and so reads as illegal.
          if ((h_hit & ~(c_set | h_set)) != '0) h_set_nx = h_set | h_hit;
          else                                  illegal_nx = 1'b1;
          state_nx = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (enter_L) begin
          illegal_nx = 1'b0;
          if (illegal_r) begin
            state_nx = WAIT_H;
          end else if (has_win(h_set)) begin
            h_win_nx = 1'b1;
            state_nx = DONE;
          end else if (&(c_set | h_set) || count(c_set) >= PICKS) begin
            draw_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = COMP;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !newGame_L) begin
      state     <= COMP;
      c_set     <= '0;
      h_set     <= '0;
      c_move    <= '0;
      c_win     <= 1'b0;
      h_win     <= 1'b0;
      draw_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state     <= state_nx;
      c_set     <= c_set_nx;
      h_set     <= h_set_nx;
      c_move    <= c_move_nx;
      c_win     <= c_win_nx;
      h_win     <= h_win_nx;
      draw_r    <= draw_nx;
      illegal_r <= illegal_nx;
    end
  end

  assign cMove   = c_move;
  assign hPicks  = pack(h_set);
  assign cPicks  = pack(c_set);
  assign cWin    = c_win;
  assign hWin    = h_win;
  assign draw    = draw_r;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_pick_sum_game.sv
// Directed bench for pick_sum_game at default parameters (NUM_MAX=9, TARGET=15, PICKS=4).
module tb_pick_sum_game;

  logic        clock = 1'b0;
  logic        reset, newGame_L, enter_L;
  logic [3:0]  hMove, cMove;
  logic [15:0] hPicks, cPicks;
  logic        cWin, hWin, draw, illegal;
  int          total = 0;
  int          bad   = 0;

  pick_sum_game dut (
    .clock(clock), .reset(reset), .newGame_L(newGame_L), .enter_L(enter_L),
    .hMove(hMove), .cMove(cMove), .hPicks(hPicks), .cPicks(cPicks),
    .cWin(cWin), .hWin(hWin), .draw(draw), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, cWin, hWin, draw, illegal}, {28'd0, exp});
  endtask

  task automatic check_fresh(input string tag);
    check({tag, "_cmove"}, cMove, 5);
    check({tag, "_cpicks"}, cPicks, 16'h0005);
    check({tag, "_hpicks"}, hPicks, 16'h0000);
    check_flags({tag, "_flags"}, 4'b0000);
  endtask

  // Press, release, then give the computer its one COMP cycle.
  task automatic human_move(input logic [3:0] v);
    hMove = v;
    enter_L = 1'b0;
    step();
    enter_L = 1'b1;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; newGame_L = 1'b1; enter_L = 1'b1; hMove = '0;
    step();
    step();
    check("rst_cmove", cMove, 0);
    check("rst_cpicks", cPicks, 0);
    check("rst_hpicks", hPicks, 0);
    check_flags("rst_flags", 4'b0000);

    reset = 1'b0;
    step();
    check_fresh("open");

    // Already-used number, held two cycles.
    hMove = 4'd5; enter_L = 1'b0;
    step();
    check_flags("ill5_set", 4'b0001);
    step();
    check_flags("ill5_held", 4'b0001);
    check("ill5_hpicks", hPicks, 0);
    enter_L = 1'b1;
    step();
    check_flags("ill5_clear", 4'b0000);
    check("ill5_cmove", cMove, 5);

    // Out-of-range number.
    hMove = 4'd10; enter_L = 1'b0;
    step();
    check_flags("ill10_set", 4'b0001);
    enter_L = 1'b1;
    step();
    check_flags("ill10_clear", 4'b0000);
    check("ill10_hpicks", hPicks, 0);

    // Legal 6 held three cycles: recorded once.
    hMove = 4'd6; enter_L = 1'b0;
    step(); step(); step();
    check("h6_hpicks", hPicks, 16'h0006);
    check("h6_cmove_hold", cMove, 5);
    enter_L = 1'b1;
    step();
    step();
    check("h6_cmove", cMove, 1);
    check("h6_cpicks", cPicks, 16'h0051);

    human_move(4'd9);
    check("h9_cmove", cMove, 2);
    check("h9_cpicks", cPicks, 16'h0521);
    check("h9_hpicks", hPicks, 16'h0096);

    human_move(4'd3);
    check("h3_cmove", cMove, 8);
    check("h3_cpicks", cPicks, 16'h8521);
    check("h3_hpicks", hPicks, 16'h0963);
    check_flags("h3_cwin", 4'b1000);

    // DONE ignores further moves.
    hMove = 4'd4; enter_L = 1'b0;
    step(); step();
    enter_L = 1'b1;
    step(); step();
    check("done_hpicks", hPicks, 16'h0963);
    check("done_cmove", cMove, 8);
    check_flags("done_flags", 4'b1000);

    // newGame_L from DONE, then mid-game while in WAIT_REL.
    newGame_L = 1'b0;
    step();
    newGame_L = 1'b1;
    step();
    check_fresh("ng_done");
    hMove = 4'd6; enter_L = 1'b0;
    step();
    check("ng_mid_hpicks", hPicks, 16'h0006);
    newGame_L = 1'b0;
    step();
    newGame_L = 1'b1; enter_L = 1'b1;
    step();
    check_fresh("ng_mid");

    // reset and newGame_L together.
    hMove = 4'd6; enter_L = 1'b0;
    step();
    reset = 1'b1; newGame_L = 1'b0;
    step();
    reset = 1'b0; newGame_L = 1'b1; enter_L = 1'b1;
    step();
    check_fresh("both");

    // Drawn game: human 2,9,6,3 against computer 5,1,4,7.
    human_move(4'd2);
    check("d2_cmove", cMove, 1);
    check("d2_cpicks", cPicks, 16'h0051);
    human_move(4'd9);
    check("d9_cmove", cMove, 4);
    check("d9_cpicks", cPicks, 16'h0541);
    human_move(4'd6);
    check("d6_cmove", cMove, 7);
    check("d6_cpicks", cPicks, 16'h7541);
    check_flags("d6_flags", 4'b0000);
    human_move(4'd3);
    check("d3_hpicks", hPicks, 16'h9632);
    check("d3_cmove", cMove, 7);
    check_flags("d3_draw", 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
